// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: shared constants and types for the RGB PWM output stage
package rgb_pwm_pkg;

    localparam int DUTY_W_DEF   = 8;
    localparam int PRESCALE_DEF = 47;
    localparam int PWM_MAX      = 2 ** DUTY_W_DEF - 1;

    typedef struct packed {
        logic [DUTY_W_DEF-1:0] r;
        logic [DUTY_W_DEF-1:0] g;
        logic [DUTY_W_DEF-1:0] b;
    } rgb_t;

endpackage

// File: rtl/rgb_pwm_if.sv
// rgb_pwm_if: valid/ready setpoint channel carrying one RGB duty triple
interface rgb_pwm_if #(
    parameter int DUTY_W = 8
);

    logic              in_valid;
    logic              in_ready;
    logic [DUTY_W-1:0] in_r;
    logic [DUTY_W-1:0] in_g;
    logic [DUTY_W-1:0] in_b;

    modport master (output in_valid, in_r, in_g, in_b, input in_ready);
    modport slave  (input in_valid, in_r, in_g, in_b, output in_ready);

endinterface

// File: rtl/rgb_pwm_channel.sv
// pwm_channel: one colour's active duty register and registered PWM comparator (fade stepping under RGB_PWM_FADE_EN)
module pwm_channel #(
    parameter int DUTY_W     = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boundary,
    input  logic              load,
    input  logic [DUTY_W-1:0] load_val,
    input  logic [DUTY_W-1:0] cnt,
    output logic              led
);

    logic [DUTY_W-1:0] active_q, active_d;
    logic              led_q, led_d;

`ifdef RGB_PWM_FADE_EN
    logic [DUTY_W-1:0] target_q, target_d;

    // retarget on every accepted setpoint; walk active one step toward target per period
    always_comb begin
        target_d = load ? load_val : target_q;
        active_d = (!boundary || active_q == target_q) ? active_q :
                   (active_q < target_q) ? active_q + 1'b1 : active_q - 1'b1;
        led_d    = (cnt < active_q) ^ ACTIVE_LOW;
    end

    // duty state and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target_q <= '0;
            active_q <= '0;
            led_q    <= ACTIVE_LOW;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            led_q    <= led_d;
        end
    end
`else
    // take the pending duty only on a period boundary so no runt pulses appear
    always_comb begin
        active_d = (boundary && load) ? load_val : active_q;
        led_d    = (cnt < active_q) ^ ACTIVE_LOW;
    end

    // duty state and output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= '0;
            led_q    <= ACTIVE_LOW;
        end else begin
            active_q <= active_d;
            led_q    <= led_d;
        end
    end
`endif

    assign led = led_q;

endmodule

// File: rtl/rgb_pwm.sv
// rgb_pwm: prescaled RGB PWM with double-buffered setpoints; define RGB_PWM_FADE_EN for per-period fading
module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int PRESCALE   = PRESCALE_DEF,
    parameter int DUTY_W     = DUTY_W_DEF,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    rgb_pwm_if.slave s,
    output logic     led_r,
    output logic     led_g,
    output logic     led_b,
    output logic     period_start
);

    localparam int PS_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    logic [PS_W-1:0]   ps_q, ps_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              period_start_q, period_start_d;
    logic              tick, boundary, accept, load;
    logic [DUTY_W-1:0] load_r, load_g, load_b;

    // prescaler tick, step counter and the period boundary
    always_comb begin
        tick           = ps_q == PS_W'(PRESCALE);
        boundary       = tick && (cnt_q == {DUTY_W{1'b1}});
        ps_d           = tick ? '0 : ps_q + 1'b1;
        cnt_d          = tick ? cnt_q + 1'b1 : cnt_q;
        period_start_d = boundary;
    end

    // timebase registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q           <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            ps_q           <= ps_d;
            cnt_q          <= cnt_d;
            period_start_q <= period_start_d;
        end
    end

`ifdef RGB_PWM_FADE_EN
    assign s.in_ready = 1'b1;
    assign accept     = s.in_valid;
    assign load       = accept;
    assign load_r     = s.in_r;
    assign load_g     = s.in_g;
    assign load_b     = s.in_b;
`else
    logic [3*DUTY_W-1:0] pend_q, pend_d;
    logic                full_q, full_d;

    // one-deep pending buffer; an accept never coincides with a release since ready requires empty
    always_comb begin
        full_d = accept ? 1'b1 : boundary ? 1'b0 : full_q;
        pend_d = accept ? {s.in_r, s.in_g, s.in_b} : pend_q;
    end

    // pending setpoint registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            pend_q <= '0;
        end else begin
            full_q <= full_d;
            pend_q <= pend_d;
        end
    end

    assign s.in_ready = !full_q;
    assign accept     = s.in_valid && !full_q;
    assign load       = full_q;
    assign load_r     = pend_q[3*DUTY_W-1 -: DUTY_W];
    assign load_g     = pend_q[2*DUTY_W-1 -: DUTY_W];
    assign load_b     = pend_q[DUTY_W-1:0];
`endif

    pwm_channel #(.DUTY_W(DUTY_W), .ACTIVE_LOW(ACTIVE_LOW)) u_r (
        .clk(clk), .rst(rst), .boundary(boundary), .load(load),
        .load_val(load_r), .cnt(cnt_q), .led(led_r)
    );

    pwm_channel #(.DUTY_W(DUTY_W), .ACTIVE_LOW(ACTIVE_LOW)) u_g (
        .clk(clk), .rst(rst), .boundary(boundary), .load(load),
        .load_val(load_g), .cnt(cnt_q), .led(led_g)
    );

    pwm_channel #(.DUTY_W(DUTY_W), .ACTIVE_LOW(ACTIVE_LOW)) u_b (
        .clk(clk), .rst(rst), .boundary(boundary), .load(load),
        .load_val(load_b), .cnt(cnt_q), .led(led_b)
    );

    assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm.sv
// tb_rgb_pwm: directed self-checking bench for rgb_pwm (PRESCALE=0, DUTY_W=8); covers fade when RGB_PWM_FADE_EN is defined
module tb_rgb_pwm;
    import rgb_pwm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic led_r, led_g, led_b, period_start;
    int   checks   = 0;
    int   failures = 0;

    rgb_pwm_if #(.DUTY_W(8)) bus ();

    rgb_pwm #(.PRESCALE(0), .DUTY_W(8), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .s(bus),
        .led_r(led_r), .led_g(led_g), .led_b(led_b), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // samples the next PWM_MAX+1 negedges; optionally offers setpoint v for one clock before sample inj
    task automatic measure(input int inj, input rgb_t v, output int nr, output int ng, output int nb,
                           output int g_first, output int g_last);
        nr = 0; ng = 0; nb = 0; g_first = -1; g_last = -1;
        for (int i = 1; i <= PWM_MAX + 1; i++) begin
            if (i == inj) begin
                bus.in_valid = 1'b1;
                bus.in_r = v.r; bus.in_g = v.g; bus.in_b = v.b;
            end
            @(negedge clk);
            if (i == inj) bus.in_valid = 1'b0;
            nr += int'(led_r); ng += int'(led_g); nb += int'(led_b);
            if (led_g) begin
                if (g_first < 0) g_first = i;
                g_last = i;
            end
        end
    endtask

    task automatic period(input string tag, input int inj, input rgb_t v, input int er, input int eg, input int eb);
        int nr, ng, nb, gf, gl;
        measure(inj, v, nr, ng, nb, gf, gl);
        chk({tag, " r_high"}, nr, er);
        chk({tag, " g_high"}, ng, eg);
        chk({tag, " b_high"}, nb, eb);
        chk({tag, " period_start"}, int'(period_start), 1);
    endtask

    initial begin
        int n, bad, nr, ng, nb, gf, gl;
        rgb_t z;
        z = '0;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;
        repeat (5) @(negedge clk);
        chk("reset leds", int'({led_r, led_g, led_b}), 0);
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk("reset period_start", int'(period_start), 0);
        rst = 1'b1;

        n = 0; bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (led_r || led_g || led_b || !bus.in_ready) bad++;
        end while (!period_start && n < 600);
        chk("first period_start delay", n, 256);
        chk("idle outputs", bad, 0);

`ifdef RGB_PWM_FADE_EN
        period("fade accept 3", 1, '{r: 8'd3, g: 8'd0, b: 8'd0}, 0, 0, 0);
        chk("fade in_ready", int'(bus.in_ready), 1);
        period("fade p1", 0, z, 1, 0, 0);
        period("fade p2", 0, z, 2, 0, 0);
        period("fade p3", 0, z, 3, 0, 0);
        period("fade accept 1", 1, '{r: 8'd1, g: 8'd0, b: 8'd0}, 3, 0, 0);
        chk("fade in_ready again", int'(bus.in_ready), 1);
        period("fade down p1", 0, z, 2, 0, 0);
        period("fade down p2", 0, z, 1, 0, 0);
        period("fade down p3", 0, z, 1, 0, 0);
`else
        period("accept 0/128/255", 1, '{r: 8'd0, g: 8'd128, b: 8'd255}, 0, 0, 0);
        measure(0, z, nr, ng, nb, gf, gl);
        chk("duty r0", nr, 0);
        chk("duty g128", ng, 128);
        chk("duty b255", nb, 255);
        chk("g first high", gf, 1);
        chk("g last high", gl, 128);

        bus.in_valid = 1'b1; bus.in_r = 8'd10; bus.in_g = 8'd128; bus.in_b = 8'd255;
        @(negedge clk);
        chk("in_ready after accept", int'(bus.in_ready), 0);
        bus.in_r = 8'd20;
        n = 1;
        while (!bus.in_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready low span", n, 256);
        chk("in_ready rises at period_start", int'(period_start), 1);
        period("r10 period", 1, '{r: 8'd20, g: 8'd128, b: 8'd255}, 10, 128, 255);
        period("r20 period", 0, z, 20, 128, 255);

        period("queue r200", 1, '{r: 8'd200, g: 8'd128, b: 8'd255}, 20, 128, 255);
        period("change at cnt100", 101, '{r: 8'd7, g: 8'd128, b: 8'd255}, 200, 128, 255);
        period("r7 period", 0, z, 7, 128, 255);

        bus.in_valid = 1'b1; bus.in_r = 8'd99; bus.in_g = 8'd99; bus.in_b = 8'd99;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (49) @(negedge clk);
        chk("led_g before reset", int'(led_g), 1);
        chk("pending held", int'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        chk("async reset led_g", int'(led_g), 0);
        chk("async reset led_b", int'(led_b), 0);
        chk("async reset in_ready", int'(bus.in_ready), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        period("post reset p1", 0, z, 0, 0, 0);
        period("post reset p2", 0, z, 0, 0, 0);
        chk("post reset in_ready", int'(bus.in_ready), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
